// File: rtl/rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter and its priority encoders.
// Encoder core selectors are macros so instantiations elsewhere in the codebase keep compiling.
`ifndef V1_LINEAR
`define V1_LINEAR 1
`endif
`ifndef V2_GENERIC
`define V2_GENERIC 2
`endif

package rr_arbiter_pkg;

    localparam int ARB_NUM_REQ_DEFAULT  = 8;
    localparam int ARB_MAX_HOLD_DEFAULT = 16;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester-side bundle of the round-robin arbiter.
// Handshake: a requester holds req_i[k] until it sees grant_o[k]; while grant_valid_o is high
// the grant is stable, and done_i (or dropping req_i[k]) hands the resource back at the next edge.
interface rr_arbiter_if #(
    parameter int NUM_REQ = rr_arbiter_pkg::ARB_NUM_REQ_DEFAULT
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_i;
    logic                     done_i;
    logic [NUM_REQ-1:0]       grant_o;
    logic [IDX_W-1:0]         grant_idx_o;
    logic                     grant_valid_o;
    logic                     timeout_o;
    rr_arbiter_pkg::arb_state_t dbg_state_o;

    modport master (
        output req_i, done_i,
        input  grant_o, grant_idx_o, grant_valid_o, timeout_o, dbg_state_o
    );

    modport slave (
        input  req_i, done_i,
        output grant_o, grant_idx_o, grant_valid_o, timeout_o, dbg_state_o
    );
endinterface

// File: rtl/priority_encoder.sv
// Highest-set-bit priority encoder; valid_o flags a nonzero input.
// Both cores give identical results, they differ only in loop structure.
module priority_encoder #(
    parameter int CORE_VERSION = `V2_GENERIC,
    parameter int DATA_WIDTH   = 8,
    localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  valid_o
);
    generate
        if (CORE_VERSION == `V2_GENERIC) begin : g_v2
            // Ascending scan: the last set bit seen is the highest one.
            always_comb begin
                idx_o = '0;
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (data_i[i]) idx_o = IDX_W'(i);
                end
            end
        end else begin : g_v1
            logic found;
            always_comb begin
                idx_o = '0;
                found = 1'b0;
                for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                    if (data_i[i] && !found) begin
                        idx_o = IDX_W'(i);
                        found = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign valid_o = |data_i;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant, held until done, withdrawal or timeout.
// Priority is highest-index-first below the last holder, wrapping to the full vector.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ_DEFAULT,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input logic         clk_i,
    input logic         rst_n_i,
    rr_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit HOLD_EN = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] cand, rot_mask, masked, win_oh;
    logic [IDX_W-1:0]   ptr, m_idx, u_idx, win_idx;
    logic               m_valid, u_valid, win_valid;
    logic               rel_done, rel_wd, rel_to, release_now;

    // The releasing holder is excluded from the handover and becomes the rotation pointer at once.
    always_comb begin
        rel_done    = bus.done_i;
        rel_wd      = ~bus.req_i[grant_idx_q];
        rel_to      = HOLD_EN && (hold_cnt_q == HOLD_LAST);
        release_now = (state_q == ARB_BUSY) && (rel_done || rel_wd || rel_to);
        cand        = (state_q == ARB_BUSY) ? (bus.req_i & ~grant_q) : bus.req_i;
        ptr         = release_now ? grant_idx_q : last_idx_q;
        rot_mask    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot_mask[i] = (IDX_W'(i) < ptr);
        end
        masked = cand & rot_mask;
    end

    priority_encoder #(.CORE_VERSION(`V2_GENERIC), .DATA_WIDTH(NUM_REQ)) u_enc_masked (
        .data_i (masked),
        .idx_o  (m_idx),
        .valid_o(m_valid)
    );

    priority_encoder #(.CORE_VERSION(`V2_GENERIC), .DATA_WIDTH(NUM_REQ)) u_enc_full (
        .data_i (cand),
        .idx_o  (u_idx),
        .valid_o(u_valid)
    );

    always_comb begin
        win_valid       = m_valid | u_valid;
        win_idx         = m_valid ? m_idx : u_idx;
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d     = ARB_BUSY;
                    grant_d     = win_oh;
                    grant_idx_d = win_idx;
                    hold_cnt_d  = '0;
                end
            end
            ARB_BUSY: begin
                if (release_now) begin
                    last_idx_d = grant_idx_q;
                    timeout_d  = rel_to && !rel_done && !rel_wd;
                    hold_cnt_d = '0;
                    if (win_valid) begin
                        grant_d     = win_oh;
                        grant_idx_d = win_idx;
                    end else begin
                        state_d     = ARB_IDLE;
                        grant_d     = '0;
                        grant_idx_d = '0;
                    end
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.grant_o       = grant_q;
    assign bus.grant_idx_o   = grant_idx_q;
    assign bus.grant_valid_o = (state_q == ARB_BUSY);
    assign bus.timeout_o     = timeout_q;
    assign bus.dbg_state_o   = state_q;
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among NUM_REQ requesters.
- Grants exactly one requester at a time and holds the grant until one of three events: the requester signals completion, the requester withdraws, or a hold-timeout expires.
- Arbitration uses two priority_encoder instances (masked and unmasked request vectors), so highest-index-first priority rotates downward after each grant.

Parameters:
- NUM_REQ, 8, number of requesters; must be >=2.
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  request vector; bit k is requester k.
- done_i  in  1  the granted requester has finished with the resource.
- grant_o  out  NUM_REQ  one-hot grant, registered; all zero when idle.
- grant_idx_o  out  $clog2(NUM_REQ)  binary index of the granted requester; 0 when idle.
- grant_valid_o  out  1  a grant is active.
- timeout_o  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - grant_o=0, grant_idx_o=0, grant_valid_o=0, timeout_o=0.
  - state=IDLE, last_idx=0, hold_cnt=0.
- Arbitration function, applied to a candidate vector C:
  - masked = C & ((1<<last_idx)-1). If masked is nonzero, the winner is the highest set bit of masked.
  - Otherwise, if C is nonzero, the winner is the highest set bit of C.
  - Otherwise there is no winner.
- IDLE state:
  - If |req_i, then C=req_i. On the next edge, register the winner into grant_o/grant_idx_o, set grant_valid_o=1 and hold_cnt=0, and go to BUSY.
  - Latency is 1 cycle from request to grant.
- BUSY state:
  - grant_o, grant_idx_o and grant_valid_o are stable.
  - hold_cnt increments every cycle. hold_cnt width is $clog2(MAX_HOLD+1), and it saturates when MAX_HOLD=0.
- Release conditions in BUSY, in priority order:
  1. done_i=1.
  2. req_i[grant_idx_o]=0 (withdrawn).
  3. MAX_HOLD>0 and hold_cnt==MAX_HOLD-1 (timeout).
- On release:
  - last_idx <= grant_idx_o.
  - C = req_i & ~grant_o, so the releasing requester is always excluded from the back-to-back decision.
  - If there is a winner: on the next edge, grant it directly with no idle bubble, reset hold_cnt and stay in BUSY.
  - If there is no winner: go to IDLE with grant_valid_o=0 for at least 1 cycle. After that the previous holder may be re-granted.
- timeout_o:
  - Registered, high for exactly 1 cycle, coincident with the first cycle after a timeout release.
  - Not asserted if done_i or a withdrawal caused the release in the same cycle.
- Grant properties: at most one grant per cycle, and grant_o is always one-hot or zero.
- grant_idx_o always matches grant_o. Outputs never change except on a clock edge or on reset assertion.
- Reset mid-grant: outputs clear immediately (asynchronously), and the rotation pointer returns to 0.
- done_i in IDLE is ignored. req_i changes in BUSY have no effect except on the granted bit.

Decomposition:
- priority_encoder_package gains:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  - a localparam giving the default MAX_HOLD.
- Two priority_encoder instances, CORE_VERSION=`V2_GENERIC, DATA_WIDTH=NUM_REQ:
  - one on the masked candidate vector;
  - one on the unmasked candidate vector.
  - Their valid_o outputs select the winner.
- The one-hot decode and the counter stay inline.

Test Plan:
All scenarios use NUM_REQ=4, MAX_HOLD=4.
- Reset: drive rst_n_i=0 with req_i=4'b1111 -> all outputs 0. Release reset -> after 1 edge, grant_o=4'b1000, grant_idx_o=3.
- Rotation: req_i=4'b1010 held, done_i pulsed each time a grant is seen -> grants 4'b1000 -> 4'b0010 -> 4'b1000, back-to-back with no grant_valid_o gap.
- Single requester: req_i=4'b0100, done_i pulse -> grant 4'b0100, then grant_valid_o=0 for 1 cycle, then 4'b0100 again.
- Timeout: req_i=4'b0011, done_i=0 -> grant 4'b0010 for exactly 4 cycles, then grant 4'b0001 with timeout_o=1 for 1 cycle. done_i asserted in the 4th cycle -> same handover but timeout_o=0.
- Withdraw: grant 4'b0010 active, req_i changes to 4'b0001 -> next cycle grant 4'b0001, timeout_o=0.
- Async reset mid-grant: rst_n_i low between edges while grant 4'b0010 is active -> grant_o=0 before the next edge. After release with req_i=4'b1111 -> grant 4'b1000.
